// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and constants for the 12-hour BCD digital clock.
//                BCD digit type, field limits, the display-select encoding and
//                the hour-advance helper used by both auto-carry and the
//                manual hour button.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR_MAX   = 8'h12;
  localparam logic [7:0] HR_MIN   = 8'h01;
  localparam logic [7:0] RESET_HR = 8'h12;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_HR   = 2'b10,
    SEL_STAT = 2'b11
  } disp_sel_t;

  // Next hour on a 12-hour dial, returned as {pm, tens, ones}.
  // 12 wraps to 01 without touching pm; 11 -> 12 flips AM/PM.
  function automatic logic [8:0] hour_next(input logic [7:0] hr, input logic pm);
    bcd_digit_t tens;
    bcd_digit_t ones;
    logic       pm_n;
    tens = hr[7:4];
    ones = hr[3:0];
    pm_n = pm;
    if (hr == HR_MAX) begin
      tens = HR_MIN[7:4];
      ones = HR_MIN[3:0];
    end else begin
      if (hr == 8'h11) pm_n = ~pm;
      if (ones == 4'd9) begin
        ones = 4'd0;
        tens = tens + 4'd1;
      end else begin
        ones = ones + 4'd1;
      end
    end
    return {pm_n, tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_bcd_mod60.sv
`default_nettype none
// ============================================================================
//  Module      : clock_bcd_mod60
//  Description : Two-digit BCD counter 00..59 with increment, clear and a
//                carry-out that fires on the increment that wraps 59 -> 00.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                inc        - advance by one this cycle
//                clr        - force to 00 (wins over inc)
//                value[7:0] - {tens, ones} BCD
//                carry      - combinational, high when inc wraps 59 -> 00
//  Revision    : 1.0  initial release
// ============================================================================
module clock_bcd_mod60
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  bcd_digit_t tens;
  bcd_digit_t ones;

  assign value = {tens, ones};
  assign carry = inc & ~clr & (value == SEC_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd5) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tt_um_ritish_behera_digital_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_ritish_behera_digital_clock
//  Description : 12-hour hh:mm:ss AM/PM clock tile. Prescaler derives a
//                once-per-second tick; buttons are 2-flop synchronised and
//                rising-edge detected for manual setting.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                ena       - tile enable, 0 freezes every register
//                ui_in     - [0] set_mode [1] hour_inc [2] min_inc [3] sec_clr
//                            [5:4] display select, [7:6] unused
//                uo_out    - {tens, ones} BCD of the selected field
//                uio_in    - unused
//                uio_out   - [0] pm [1] sec_tick [2] set_mode [3] chime
//                uio_oe    - constant 8'h0F
//  Config      : CHIME_EN - when defined, chime is high for one second after
//                an auto-advance lands on mm:ss = 00:00
//  Revision    : 1.0  initial release
// ============================================================================
module tt_um_ritish_behera_digital_clock
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  // ---------------- input synchronisers and edge detect ----------------
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] btn_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 4'd0;
      sync2    <= 4'd0;
      btn_prev <= 4'd0;
    end else if (ena) begin
      sync1    <= ui_in[3:0];
      sync2    <= sync1;
      btn_prev <= sync2;
    end
  end

  logic [3:0] btn_rise;
  logic       set_mode;
  logic       sec_clr;
  logic       hr_btn;
  logic       min_btn;

  assign btn_rise = sync2 & ~btn_prev;
  assign set_mode = sync2[0];
  assign sec_clr  = ena & btn_rise[3];
  assign hr_btn   = ena & set_mode & btn_rise[1];
  assign min_btn  = ena & set_mode & btn_rise[2];

  // ---------------- prescaler and second tick ----------------
  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          wrap;
  logic          advance;

  assign wrap    = (presc == PRESC_LAST);
  // sec_clr suppresses a coincident tick entirely.
  assign advance = ena & ~set_mode & ~btn_rise[3] & wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (ena) begin
      if (btn_rise[3]) begin
        presc    <= '0;
        sec_tick <= 1'b0;
      end else if (set_mode) begin
        sec_tick <= 1'b0;
      end else if (wrap) begin
        presc    <= '0;
        sec_tick <= 1'b1;
      end else begin
        presc    <= presc + 1'b1;
        sec_tick <= 1'b0;
      end
    end
  end

  // ---------------- seconds / minutes ----------------
  logic [7:0] sec;
  logic [7:0] min;
  logic       sec_carry;
  logic       min_carry;

  clock_bcd_mod60 u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (advance),
    .clr   (sec_clr),
    .value (sec),
    .carry (sec_carry)
  );

  // Auto carry and the manual button are mutually exclusive by set_mode.
  clock_bcd_mod60 u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_carry | min_btn),
    .clr   (1'b0),
    .value (min),
    .carry (min_carry)
  );

  // ---------------- hours / pm ----------------
  logic [7:0] hr;
  logic       pm;
  logic       hr_inc;

  // Manual minute wraps never carry into hours.
  assign hr_inc = set_mode ? hr_btn : min_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      hr <= RESET_HR;
      pm <= 1'b0;
    end else if (hr_inc) begin
      {pm, hr} <= hour_next(hr, pm);
    end
  end

  // ---------------- chime ----------------
  logic chime;
`ifdef CHIME_EN
  logic [PW-1:0] chime_cnt;
  logic          top_of_hour;

  // Minute carry outside set mode only comes from an auto-advance.
  assign top_of_hour = min_carry & ~set_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      chime     <= 1'b0;
      chime_cnt <= '0;
    end else if (ena) begin
      if (top_of_hour) begin
        chime     <= 1'b1;
        chime_cnt <= '0;
      end else if (chime) begin
        if (chime_cnt == PRESC_LAST) chime <= 1'b0;
        else                         chime_cnt <= chime_cnt + 1'b1;
      end
    end
  end
`else
  assign chime = 1'b0;
`endif

  // ---------------- outputs ----------------
  always_comb begin
    uo_out = 8'h00;
    case (disp_sel_t'(ui_in[5:4]))
      SEL_SEC:  uo_out = sec;
      SEL_MIN:  uo_out = min;
      SEL_HR:   uo_out = hr;
      SEL_STAT: uo_out = {3'b000, pm, 4'h0};
      default:  uo_out = 8'h00;
    endcase
  end

  assign uio_out = {4'h0, chime, set_mode, sec_tick, pm};
  assign uio_oe  = 8'h0F;

  logic unused_inputs;
  assign unused_inputs = ^{uio_in, ui_in[7:6], MIN_MAX};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_ritish_behera_digital_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_ritish_behera_digital_clock
//  Description : Self-checking bench for the 12-hour clock tile. Reference
//                model keeps time as seconds-of-day (0..86399) and derives
//                12-hour fields arithmetically.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tt_um_ritish_behera_digital_clock;

  localparam int CLK_DIV = 4;
`ifdef CHIME_EN
  localparam bit CHIME = 1'b1;
`else
  localparam bit CHIME = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_ritish_behera_digital_clock #(.CLK_DIV(CLK_DIV)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int tests = 0;
  int fails = 0;
  int tick_seen = 0;
  int tick_double = 0;
  bit last_tick = 1'b0;

  // ---------------- reference model ----------------
  int         m_tod = 0;        // seconds since 12:00:00 AM
  int         m_presc = 0;
  bit         m_tick = 1'b0;
  int         m_chime_left = 0;
  logic [3:0] m_seen1 = '0, m_seen2 = '0, m_seen3 = '0; // input as seen 1/2/3 enabled edges ago

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int hr24();
    return m_tod / 3600;
  endfunction

  function automatic int hr12();
    return (hr24() % 12 == 0) ? 12 : hr24() % 12;
  endfunction

  function automatic logic [7:0] exp_uo(input logic [1:0] sel);
    case (sel)
      2'd0:    return to_bcd(m_tod % 60);
      2'd1:    return to_bcd((m_tod / 60) % 60);
      2'd2:    return to_bcd(hr12());
      default: return {3'b000, (hr24() >= 12), 4'h0};
    endcase
  endfunction

  function automatic logic [7:0] exp_uio();
    return {4'h0, (CHIME && m_chime_left > 0), m_seen2[0], m_tick, (hr24() >= 12)};
  endfunction

  function automatic void model_step();
    logic [3:0] rise;
    bit         setm;
    bit         adv;
    int         mins;
    if (rst) begin
      m_tod = 0; m_presc = 0; m_tick = 0; m_chime_left = 0;
      m_seen1 = '0; m_seen2 = '0; m_seen3 = '0;
      return;
    end
    if (!ena) return;
    rise = m_seen2 & ~m_seen3;
    setm = m_seen2[0];
    adv  = 1'b0;
    m_seen3 = m_seen2; m_seen2 = m_seen1; m_seen1 = ui_in[3:0];
    if (rise[3]) begin
      m_tod   = m_tod - (m_tod % 60);
      m_presc = 0;
      m_tick  = 0;
    end else if (setm) begin
      m_tick = 0;
    end else if (m_presc == CLK_DIV - 1) begin
      m_presc = 0; m_tick = 1; adv = 1'b1;
    end else begin
      m_presc++; m_tick = 0;
    end
    if (setm && rise[1]) m_tod = (m_tod + 3600) % 86400;
    if (setm && rise[2]) begin
      mins  = (m_tod / 60) % 60;
      m_tod = m_tod - mins * 60 + ((mins + 1) % 60) * 60;
    end
    if (adv) begin
      m_tod = (m_tod + 1) % 86400;
      if (m_tod % 3600 == 0) m_chime_left = CLK_DIV + 1;
    end
    if (m_chime_left > 0) m_chime_left--;
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tests++;
    if (uo_out !== exp_uo(ui_in[5:4]) || uio_out !== exp_uio() || uio_oe !== 8'h0F) begin
      fails++;
      $display("FAIL model t=%0t: uo_out=%h uio_out=%h uio_oe=%h expected %h %h 0f",
               $time, uo_out, uio_out, uio_oe, exp_uo(ui_in[5:4]), exp_uio());
    end
    if (uio_out[1]) tick_seen++;
    if (uio_out[1] && last_tick) tick_double++;
    last_tick = uio_out[1];
  endtask

  task automatic check_field(input string name, input logic [1:0] sel, input logic [7:0] exp);
    ui_in[5:4] = sel;
    #1;
    tests++;
    if (uo_out !== exp) begin
      fails++;
      $display("FAIL %s: uo_out=%h expected %h", name, uo_out, exp);
    end
  endtask

  task automatic press(input int b);
    ui_in[b] = 1'b1;
    repeat (4) step();
    ui_in[b] = 1'b0;
    repeat (4) step();
  endtask

  task automatic check_chime(input string name);
    int cnt;
    cnt = int'(uio_out[3]);
    repeat (7) begin
      step();
      cnt += int'(uio_out[3]);
    end
    tests++;
    if (cnt != (CHIME ? CLK_DIV : 0)) begin
      fails++;
      $display("FAIL %s: chime cycles=%0d expected %0d", name, cnt, CHIME ? CLK_DIV : 0);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] ui;
    int         n;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, 1'b1, 8'h00, 2,   8'h00, 8'h00}; // reset: seconds
    vt[1] = '{1'b1, 1'b1, 8'h20, 1,   8'h12, 8'h00}; // reset: hours = 12
    vt[2] = '{1'b1, 1'b1, 8'h30, 1,   8'h00, 8'h00}; // reset: AM
    vt[3] = '{1'b0, 1'b1, 8'h00, 240, 8'h00, 8'h02}; // one minute: sec 00, tick now
    vt[4] = '{1'b0, 1'b1, 8'h10, 1,   8'h01, 8'h00}; // minutes = 01
    vt[5] = '{1'b0, 1'b1, 8'h20, 2,   8'h12, 8'h00}; // hours unchanged
    vt[6] = '{1'b0, 1'b1, 8'h01, 3,   8'h01, 8'h04}; // enter set mode, one more tick

    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst; ena = vt[i].ena; ui_in = vt[i].ui;
      if (i == 3) begin tick_seen = 0; tick_double = 0; end
      repeat (vt[i].n) step();
      tests++;
      if (uo_out !== vt[i].exp_uo || uio_out !== vt[i].exp_uio) begin
        fails++;
        $display("FAIL vec%0d: uo_out=%h uio_out=%h expected %h %h",
                 i, uo_out, uio_out, vt[i].exp_uo, vt[i].exp_uio);
      end
      if (i == 3) begin
        tests++;
        if (tick_seen != 60 || tick_double != 0) begin
          fails++;
          $display("FAIL tick_count: pulses=%0d doubles=%0d expected 60 0", tick_seen, tick_double);
        end
      end
    end

    // ---- set mode: now 12:01:01 AM, frozen ----
    repeat (13) press(1);
    check_field("set_hr13", 2'd2, 8'h01);
    check_field("set_pm13", 2'd3, 8'h10);
    repeat (60) press(2);
    check_field("set_min60", 2'd1, 8'h01);
    check_field("set_hr_keep", 2'd2, 8'h01);
    check_field("set_sec_frozen", 2'd0, 8'h01);

    // ---- rollover 11:59 AM -> 12:00:00 PM ----
    repeat (22) press(1);
    check_field("set_hr11", 2'd2, 8'h11);
    check_field("set_am11", 2'd3, 8'h00);
    repeat (58) press(2);
    press(3);
    check_field("sec_clr", 2'd0, 8'h00);
    ui_in[0] = 1'b0;
    repeat (2 + 60 * CLK_DIV) step();
    check_field("roll_sec", 2'd0, 8'h00);
    check_field("roll_min", 2'd1, 8'h00);
    check_field("roll_hr", 2'd2, 8'h12);
    check_field("roll_pm", 2'd3, 8'h10);
    check_chime("chime_noon");

    // ---- 12:59:59 PM -> 01:00:00 PM ----
    ui_in[0] = 1'b1;
    repeat (3) step();
    repeat (59) press(2);
    press(3);
    ui_in[0] = 1'b0;
    repeat (2 + 59 * CLK_DIV) step();
    check_field("pre_sec", 2'd0, 8'h59);
    check_field("pre_min", 2'd1, 8'h59);
    repeat (CLK_DIV) step();
    check_field("one_hr", 2'd2, 8'h01);
    check_field("one_min", 2'd1, 8'h00);
    check_field("one_pm", 2'd3, 8'h10);
    check_chime("chime_one");

    // ---- ena low freezes everything ----
    ui_in = 8'h02;
    ena = 1'b0;
    repeat (100) step();
    ui_in = 8'h00;
    ena = 1'b1;
    repeat (20) step();

    // ---- randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] v;
      v = ui_in;
      if ($urandom_range(0, 39) == 0) v[0] = ~v[0];
      for (int b = 1; b < 4; b++) v[b] = ($urandom_range(0, 3) == 0);
      v[7:4] = 4'($urandom);
      ui_in  = v;
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
